// File: rtl/btn_debouncer.sv
// Multi-channel push-button debouncer: per-channel synchronizer, 4-state
// qualification FSM with its own counter, and registered level/rise/fall outputs.
module btn_debouncer #(
    parameter int N_BTN           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_rise,
    output logic [N_BTN-1:0] o_fall
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    for (genvar k = 0; k < N_BTN; k++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_chain;
        logic                   sync;
        state_t                 state;
        logic [CNT_W-1:0]       count;
        logic                   level;
        logic                   rise;
        logic                   fall;

        // Only the last synchronizer stage is allowed to reach the FSM.
        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                sync_chain <= '0;
            end else begin
                sync_chain <= {sync_chain[SYNC_STAGES-2:0], i_btn[k]};
            end
        end

        assign sync = sync_chain[SYNC_STAGES-1];

        // Any sample disagreeing with the candidate level drops back to the
        // stable state with the counter cleared, so bounce earns no credit.
        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                state <= STABLE_LOW;
                count <= '0;
                level <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                case (state)
                    STABLE_LOW: begin
                        if (sync) begin
                            state <= WAIT_HIGH;
                            count <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!sync) begin
                            state <= STABLE_LOW;
                            count <= '0;
                        end else if (count == CNT_LAST) begin
                            state <= STABLE_HIGH;
                            count <= '0;
                            level <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!sync) begin
                            state <= WAIT_LOW;
                            count <= '0;
                        end
                    end
                    WAIT_LOW: begin
                        if (sync) begin
                            state <= STABLE_HIGH;
                            count <= '0;
                        end else if (count == CNT_LAST) begin
                            state <= STABLE_LOW;
                            count <= '0;
                            level <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: begin
                        state <= STABLE_LOW;
                        count <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end

        assign o_level[k] = level;
        assign o_rise[k]  = rise;
        assign o_fall[k]  = fall;
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer: reset, clean press/release, glitch,
// bounce restart and reset during qualification, with hand-computed timing.
module tb_btn_debouncer;

    localparam int N_BTN           = 2;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LATENCY         = SYNC_STAGES + DEBOUNCE_CYCLES + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;

    int checks   = 0;
    int failures = 0;

    logic bounce [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    btn_debouncer #(
        .N_BTN          (N_BTN),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .i_btn  (btn),
        .o_level(level),
        .o_rise (rise),
        .o_fall (fall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic [1:0] exp_level,
                                input logic [1:0] exp_rise, input logic [1:0] exp_fall);
        check({tag, ".level"}, level, exp_level);
        check({tag, ".rise"},  rise,  exp_rise);
        check({tag, ".fall"},  fall,  exp_fall);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 2'b00;
        #2;
        check_output("reset_async", 2'b00, 2'b00, 2'b00);
        btn = 2'b11;
        repeat (3) tick();
        check_output("reset_held", 2'b00, 2'b00, 2'b00);
        btn   = 2'b00;
        rst_n = 1'b1;
        repeat (4) tick();
        check_output("idle", 2'b00, 2'b00, 2'b00);

        // Clean press on channel 0, held for 20 clocks
        btn = 2'b01;
        repeat (LATENCY - 1) tick();
        check_output("press_before", 2'b00, 2'b00, 2'b00);
        tick();
        check_output("press_edge", 2'b01, 2'b01, 2'b00);
        tick();
        check_output("press_after", 2'b01, 2'b00, 2'b00);
        repeat (20 - LATENCY - 1) tick();
        check_output("press_hold", 2'b01, 2'b00, 2'b00);

        // Four-clock glitch on channel 1 must be rejected
        for (int i = 0; i < 14; i++) begin
            btn = (i < 4) ? 2'b11 : 2'b01;
            tick();
            check_output("glitch", 2'b01, 2'b00, 2'b00);
        end

        // Release of channel 0, held low for 10 clocks
        btn = 2'b00;
        repeat (LATENCY - 1) tick();
        check_output("release_before", 2'b01, 2'b00, 2'b00);
        tick();
        check_output("release_edge", 2'b00, 2'b00, 2'b01);
        tick();
        check_output("release_after", 2'b00, 2'b00, 2'b00);
        repeat (10 - LATENCY - 1) tick();
        check_output("release_hold", 2'b00, 2'b00, 2'b00);

        // Channel 1 press
        btn = 2'b10;
        repeat (LATENCY - 1) tick();
        check_output("ch1_before", 2'b00, 2'b00, 2'b00);
        tick();
        check_output("ch1_edge", 2'b10, 2'b10, 2'b00);
        tick();
        check_output("ch1_after", 2'b10, 2'b00, 2'b00);

        // Bounce on channel 0: the final 0->1 sample is pattern index 4
        for (int i = 0; i < 9; i++) begin
            btn = {1'b1, bounce[i]};
            tick();
            check_output("bounce_wait", 2'b10, 2'b00, 2'b00);
        end
        tick();
        check_output("bounce_before", 2'b10, 2'b00, 2'b00);
        tick();
        check_output("bounce_edge", 2'b11, 2'b01, 2'b00);
        tick();
        check_output("bounce_after", 2'b11, 2'b00, 2'b00);

        // Drop channel 0 again so it can be re-qualified under reset
        btn = 2'b10;
        repeat (LATENCY - 1) tick();
        check_output("drop_before", 2'b11, 2'b00, 2'b00);
        tick();
        check_output("drop_edge", 2'b10, 2'b00, 2'b01);
        tick();

        // Reset two clocks into WAIT_HIGH on channel 0
        btn = 2'b11;
        repeat (5) tick();
        check_output("midqual", 2'b10, 2'b00, 2'b00);
        rst_n = 1'b0;
        #2;
        check_output("midqual_reset_async", 2'b00, 2'b00, 2'b00);
        repeat (2) tick();
        check_output("midqual_reset_held", 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        repeat (LATENCY - 1) tick();
        check_output("post_reset_before", 2'b00, 2'b00, 2'b00);
        tick();
        check_output("post_reset_edge", 2'b11, 2'b11, 2'b00);
        tick();
        check_output("post_reset_after", 2'b11, 2'b00, 2'b00);
        repeat (5) tick();
        check_output("post_reset_hold", 2'b11, 2'b00, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
